// File: rtl/colorizer_pkg.sv
// Shared types and constants for the layer colorizer.
// Pixel layout is {valid, B, G, R} with one nibble per channel.
package colorizer_pkg;

  typedef struct packed {
    logic        valid;
    logic [11:0] rgb;
  } pix_t;

  localparam logic [1:0] MAP_DIRT  = 2'd0;
  localparam logic [1:0] MAP_PATH  = 2'd1;
  localparam logic [1:0] MAP_WALL  = 2'd2;
  localparam logic [1:0] MAP_GRASS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLASH,
    ST_COOLDOWN
  } flash_st_e;

  localparam int COOL_FRAMES = 8;

  // A sprite pixel shows only when valid and not the colour key.
  function automatic logic opaque(pix_t p, logic [11:0] key);
    return p.valid && (p.rgb != key);
  endfunction

endpackage

// File: rtl/layer_colorizer_vid_delay.sv
// vid_delay: aligns video_on with the layer pixel pipeline.
// DEPTH=0 is a plain wire; otherwise a resettable shift chain.
module vid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic out_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign out_o = in_i;
  end else begin : g_pipe
    logic [DEPTH-1:0] pipe_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= in_i;
        for (int i = 1; i < DEPTH; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign out_o = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/layer_colorizer.sv
// layer_colorizer: sprite/world layer mux, collision flag, hit flash.
// Define LAYER_COLORIZER_FLASH_EN to build in the hit-flash FSM.
module layer_colorizer
  import colorizer_pkg::*;
#(
  parameter int          VIDEO_DLY    = 2,
  parameter logic [11:0] TRANSPARENT  = 12'h000,
  parameter logic [11:0] PATH_COLOR   = 12'h864,
  parameter int          FLASH_FRAMES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic [1:0]  world,
  input  logic [12:0] death_pixel,
  input  logic [12:0] rock_pixel,
  input  logic [12:0] grass_pixel,
  input  logic [12:0] mil_pixel,
  input  logic [12:0] mon_pixel,
  input  logic        hit,
  output logic [3:0]  vga_red,
  output logic [3:0]  vga_green,
  output logic [3:0]  vga_blue,
  output logic        collision,
  output logic        flash_active
);

  pix_t        death;
  pix_t        rock;
  pix_t        grass;
  pix_t        mil;
  pix_t        mon;
  pix_t        world_p;
  logic        vid_d;
  logic        mon_op;
  logic        mil_op;
  logic        invert;
  logic        coll_now;
  logic [11:0] rgb_d;
  logic [11:0] rgb_q;
  logic        coll_seen_q;
  logic        collision_q;

  assign death = death_pixel;
  assign rock  = rock_pixel;
  assign grass = grass_pixel;
  assign mil   = mil_pixel;
  assign mon   = mon_pixel;

  vid_delay #(
    .DEPTH (VIDEO_DLY)
  ) u_vid_delay (
    .clk   (clk),
    .reset (reset),
    .in_i  (video_on),
    .out_o (vid_d)
  );

  assign mon_op   = opaque(mon, TRANSPARENT);
  assign mil_op   = opaque(mil, TRANSPARENT);
  assign coll_now = vid_d && mon_op && mil_op;

  always_comb begin
    world_p = death;
    unique case (world)
      MAP_DIRT:  world_p = death;
      MAP_PATH:  world_p = '{valid: 1'b1, rgb: PATH_COLOR};
      MAP_WALL:  world_p = rock;
      MAP_GRASS: world_p = grass;
      default:   world_p = death;
    endcase
  end

  always_comb begin
    rgb_d = 12'h000;
    if (mon_op) begin
      rgb_d = mon.rgb;
    end else if (mil_op) begin
      rgb_d = invert ? ~mil.rgb : mil.rgb;
    end else if (world_p.valid) begin
      rgb_d = world_p.rgb;
    end
    if (!vid_d) begin
      rgb_d = 12'h000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= 12'h000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  // A hit on the frame_start cycle belongs to the frame just beginning.
  always_ff @(posedge clk) begin
    if (reset) begin
      coll_seen_q <= 1'b0;
      collision_q <= 1'b0;
    end else if (frame_start) begin
      collision_q <= coll_seen_q;
      coll_seen_q <= coll_now;
    end else begin
      collision_q <= 1'b0;
      coll_seen_q <= coll_seen_q | coll_now;
    end
  end

`ifdef LAYER_COLORIZER_FLASH_EN
  localparam logic [5:0] FLASH_LAST = 6'(FLASH_FRAMES - 1);
  localparam logic [5:0] COOL_LAST  = 6'(COOL_FRAMES - 1);

  flash_st_e  state_q;
  logic [5:0] fcnt_q;
  logic       flash_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fcnt_q  <= 6'd0;
      flash_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (hit) begin
            state_q <= ST_FLASH;
            fcnt_q  <= 6'd0;
            flash_q <= 1'b1;
          end
        end
        ST_FLASH: begin
          if (frame_start) begin
            if (fcnt_q == FLASH_LAST) begin
              state_q <= ST_COOLDOWN;
              fcnt_q  <= 6'd0;
              flash_q <= 1'b0;
            end else begin
              fcnt_q <= fcnt_q + 6'd1;
            end
          end
        end
        ST_COOLDOWN: begin
          if (frame_start) begin
            if (fcnt_q == COOL_LAST) begin
              state_q <= ST_IDLE;
              fcnt_q  <= 6'd0;
            end else begin
              fcnt_q <= fcnt_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          fcnt_q  <= 6'd0;
          flash_q <= 1'b0;
        end
      endcase
    end
  end

  assign invert       = (state_q == ST_FLASH) && fcnt_q[2];
  assign flash_active = flash_q;
`else
  logic unused_hit;
  assign unused_hit   = hit;
  assign invert       = 1'b0;
  assign flash_active = 1'b0;
`endif

  assign vga_blue  = rgb_q[11:8];
  assign vga_green = rgb_q[7:4];
  assign vga_red   = rgb_q[3:0];
  assign collision = collision_q;

endmodule

// File: tb/tb_layer_colorizer.sv
// Randomised + directed bench for layer_colorizer with a frame-level model.
// Flash expectations follow LAYER_COLORIZER_FLASH_EN.
module tb_layer_colorizer;

  localparam int          DLY  = 2;
  localparam logic [11:0] KEY  = 12'h000;
  localparam logic [11:0] PATH = 12'h864;
  localparam int          FF   = 32;
  localparam int          COOL = 8;
`ifdef LAYER_COLORIZER_FLASH_EN
  localparam bit FLASH_ON = 1'b1;
`else
  localparam bit FLASH_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on;
  logic        frame_start;
  logic        hit;
  logic [1:0]  world;
  logic [12:0] death_p, rock_p, grass_p, mil_p, mon_p;
  logic [3:0]  vr, vg, vb;
  logic        collision, flash_active;

  always #5 clk = ~clk;

  layer_colorizer dut (
    .clk          (clk),
    .reset        (reset),
    .video_on     (video_on),
    .frame_start  (frame_start),
    .world        (world),
    .death_pixel  (death_p),
    .rock_pixel   (rock_p),
    .grass_pixel  (grass_p),
    .mil_pixel    (mil_p),
    .mon_pixel    (mon_p),
    .hit          (hit),
    .vga_red      (vr),
    .vga_green    (vg),
    .vga_blue     (vb),
    .collision    (collision),
    .flash_active (flash_active)
  );

  int errors = 0;
  int checks = 0;

  // Model: video history, collision flag, frames counted since a hit.
  bit          vhist[$];
  bit          m_seen;
  bit          m_ep;
  int          m_n;
  logic [11:0] e_rgb;
  bit          e_coll;
  bit          e_flash;

  function automatic bit opq(logic [12:0] p);
    return p[12] && (p[11:0] != KEY);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model();
    bit          vd;
    bit          inv;
    bit          cn;
    logic [12:0] w;
    logic [11:0] c;
    vd  = (DLY == 0) ? video_on : vhist[DLY-1];
    inv = FLASH_ON && m_ep && (m_n < FF) && ((m_n / 4) % 2 == 1);
    case (world)
      2'd0:    w = death_p;
      2'd1:    w = {1'b1, PATH};
      2'd2:    w = rock_p;
      default: w = grass_p;
    endcase
    if (opq(mon_p))      c = mon_p[11:0];
    else if (opq(mil_p)) c = inv ? ~mil_p[11:0] : mil_p[11:0];
    else if (w[12])      c = w[11:0];
    else                 c = 12'h000;
    if (!vd) c = 12'h000;
    if (reset) begin
      e_rgb  = 12'h000;
      e_coll = 1'b0;
      m_seen = 1'b0;
      m_ep   = 1'b0;
      m_n    = 0;
      foreach (vhist[i]) vhist[i] = 1'b0;
    end else begin
      e_rgb = c;
      cn = vd && opq(mon_p) && opq(mil_p);
      if (frame_start) begin
        e_coll = m_seen;
        m_seen = cn;
      end else begin
        e_coll = 1'b0;
        m_seen = m_seen | cn;
      end
      if (FLASH_ON) begin
        if (m_ep) begin
          if (frame_start) m_n++;
          if (m_n == FF + COOL) m_ep = 1'b0;
        end else if (hit) begin
          m_ep = 1'b1;
          m_n  = 0;
        end
      end
      if (DLY > 0) begin
        vhist.push_front(video_on);
        void'(vhist.pop_back());
      end
    end
    e_flash = m_ep && (m_n < FF);
  endtask

  // The single compare point: every cycle, 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("rgb", {20'h0, vb, vg, vr}, {20'h0, e_rgb});
    chk("collision", {31'h0, collision}, {31'h0, e_coll});
    chk("flash_active", {31'h0, flash_active}, {31'h0, e_flash});
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  task automatic clear_layers();
    mon_p   = 13'h0;
    mil_p   = 13'h0;
    death_p = 13'h0;
    rock_p  = 13'h0;
    grass_p = 13'h0;
    world   = 2'd0;
  endtask

  function automatic logic [12:0] rpix(int pct);
    logic [11:0] c;
    c = ($urandom_range(0, 4) == 0) ? KEY : 12'($urandom);
    return {($urandom_range(0, 99) < pct), c};
  endfunction

  function automatic logic [11:0] rgb_now();
    return {vb, vg, vr};
  endfunction

  initial begin
    for (int i = 0; i < DLY; i++) vhist.push_back(1'b0);
    m_seen = 0; m_ep = 0; m_n = 0;
    reset = 1'b1; video_on = 1'b0; frame_start = 1'b0; hit = 1'b0;
    clear_layers();
    step();
    step();
    chk("reset_rgb", {20'h0, rgb_now()}, 32'h0);
    chk("reset_coll", {31'h0, collision}, 32'h0);
    chk("reset_flash", {31'h0, flash_active}, 32'h0);
    reset = 1'b0;
    video_on = 1'b1;
    repeat (3) step();

    mon_p = 13'h1F00; mil_p = 13'h10F0; world = 2'd2; rock_p = 13'h1ABC;
    step();
    chk("prio_mon", {20'h0, rgb_now()}, 32'hF00);
    mon_p = 13'h1000;
    step();
    chk("prio_mil", {20'h0, rgb_now()}, 32'h0F0);
    mil_p = 13'h00F0;
    step();
    chk("prio_world", {20'h0, rgb_now()}, 32'hABC);

    clear_layers();
    world = 2'd1;
    step();
    chk("path_rgb", {20'h0, rgb_now()}, 32'h864);
    chk("path_blue", {28'h0, vb}, 32'h8);

    video_on = 1'b0;
    mon_p = 13'h1F00; mil_p = 13'h10F0; world = 2'd2; rock_p = 13'h1ABC;
    repeat (DLY + 1) step();
    chk("blank_rgb", {20'h0, rgb_now()}, 32'h0);
    video_on = 1'b1;
    clear_layers();
    repeat (DLY + 1) step();

    frame();
    mon_p = 13'h1F00; mil_p = 13'h10F0;
    step();
    clear_layers();
    repeat (2) step();
    frame_start = 1'b1;
    step();
    chk("coll_pulse", {31'h0, collision}, 32'h1);
    frame_start = 1'b0;
    step();
    chk("coll_one_cycle", {31'h0, collision}, 32'h0);
    frame_start = 1'b1;
    step();
    chk("coll_next_frame", {31'h0, collision}, 32'h0);
    frame_start = 1'b0;
    step();

    hit = 1'b1;
    step();
    hit = 1'b0;
    repeat (5) frame();
    mil_p = 13'h1123;
    step();
`ifdef LAYER_COLORIZER_FLASH_EN
    chk("flash_invert", {20'h0, rgb_now()}, 32'hEDC);
    chk("flash_on", {31'h0, flash_active}, 32'h1);
    mil_p = 13'h0;
    repeat (26) frame();
    chk("flash_31", {31'h0, flash_active}, 32'h1);
    frame();
    chk("cooldown", {31'h0, flash_active}, 32'h0);
    repeat (7) frame();
    hit = 1'b1;
    step();
    hit = 1'b0;
    step();
    chk("cool_hit_ignored", {31'h0, flash_active}, 32'h0);
    frame();
    hit = 1'b1;
    step();
    hit = 1'b0;
    chk("idle_rehit", {31'h0, flash_active}, 32'h1);
`else
    chk("no_invert", {20'h0, rgb_now()}, 32'h123);
    chk("no_flash", {31'h0, flash_active}, 32'h0);
    mil_p = 13'h0;
`endif

    mon_p = 13'h1F00; mil_p = 13'h10F0;
    step();
    clear_layers();
    reset = 1'b1;
    step();
    chk("rst_mid_flash", {31'h0, flash_active}, 32'h0);
    chk("rst_mid_rgb", {20'h0, rgb_now()}, 32'h0);
    reset = 1'b0;
    repeat (3) step();
    frame_start = 1'b1;
    step();
    chk("rst_no_coll", {31'h0, collision}, 32'h0);
    frame_start = 1'b0;
    step();

    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 799) == 0);
      video_on    = ($urandom_range(0, 7) != 0);
      frame_start = ($urandom_range(0, 5) == 0);
      hit         = ($urandom_range(0, 39) == 0);
      world       = 2'($urandom_range(0, 3));
      mon_p       = rpix(30);
      mil_p       = rpix(50);
      death_p     = rpix(70);
      rock_p      = rpix(70);
      grass_p     = rpix(70);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
